// File: rtl/gpu_trace_renderer_pkg.sv
// Shared colour constants, default layout values and pipeline flag bundle
// for the N-channel scope trace renderer.
package gpu_trace_renderer_pkg;

  localparam logic [11:0] COLOUR_WHITE = 12'hFFF;
  localparam logic [11:0] COLOUR_TRIG  = 12'h770;
  localparam logic [11:0] COLOUR_FRAME = 12'h444;
  localparam logic [11:0] COLOUR_GRID  = 12'h222;
  localparam logic [11:0] COLOUR_BLACK = 12'h000;

  localparam int DEF_PLOT_X0    = 200;
  localparam int DEF_PLOT_X1    = 700;
  localparam int DEF_PLOT_Y0    = 50;
  localparam int DEF_PLOT_Y1    = 550;
  localparam int DEF_MID_ROW    = 300;
  localparam int DEF_TRIG_X_OFS = 193;
  localparam int DEF_TRIG_ROWS  = 100;

  typedef struct packed {
    logic on_screen;
    logic on_text;
    logic on_frame;
    logic on_grid;
    logic trig;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_IDLE = 5'b00000;

  // Anti-alias halo colour: each RGB nibble halved.
  function automatic logic [11:0] half_colour(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/gpu_trace_renderer_hit.sv
// Per-channel trace rasteriser: clamps the sample row, tracks the previous
// column's row and registers the hit / anti-alias flags for the current pixel.
module gpu_trace_hit
  import gpu_trace_renderer_pkg::*;
#(
  parameter int SAMPLE_W = 9,
  parameter int ROW_W    = 10,
  parameter int PLOT_Y0  = DEF_PLOT_Y0,
  parameter int PLOT_Y1  = DEF_PLOT_Y1,
  parameter int MID_ROW  = DEF_MID_ROW
) (
  input  logic                vga_clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [ROW_W-1:0]    row,
  input  logic                in_plot,
  input  logic                first_col,
  input  logic                enable,
  input  logic                plot_vectors,
  input  logic                aa_enable,
  output logic                hit,
  output logic                aa
);

  localparam int YW = ROW_W + 2;
  localparam logic signed [YW-1:0] MID_S = YW'(MID_ROW);
  localparam logic signed [YW-1:0] Y0_S  = YW'(PLOT_Y0);
  localparam logic signed [YW-1:0] Y1_S  = YW'(PLOT_Y1);
  localparam logic [ROW_W-1:0]     Y0_U  = ROW_W'(PLOT_Y0);
  localparam logic [ROW_W-1:0]     Y1_U  = ROW_W'(PLOT_Y1);
  localparam logic [ROW_W:0]       ONE_X = {{ROW_W{1'b0}}, 1'b1};

  logic signed [YW-1:0] y_full_s;
  logic [ROW_W-1:0]     y_s;
  logic [ROW_W-1:0]     ref_y_s;
  logic [ROW_W-1:0]     lo_s;
  logic [ROW_W-1:0]     hi_s;
  logic                 in_range_s;
  logic                 edge_s;
  logic                 hit_s;
  logic                 aa_s;
  logic [ROW_W-1:0]     prev_y_r;
  logic                 prev_valid_r;
  logic                 hit_r;
  logic                 aa_r;

  // Clamp the sample row and derive the vertical span drawn in this column.
  always_comb begin
    y_full_s = MID_S - $signed({{(YW-SAMPLE_W){sample[SAMPLE_W-1]}}, sample});
    if (y_full_s < Y0_S) begin
      y_s = Y0_U;
    end else if (y_full_s > Y1_S) begin
      y_s = Y1_U;
    end else begin
      y_s = y_full_s[ROW_W-1:0];
    end

    // A new line (or a fresh reset) never connects to a stale previous row.
    if (first_col || !prev_valid_r) begin
      ref_y_s = y_s;
    end else begin
      ref_y_s = prev_y_r;
    end

    if (!plot_vectors) begin
      lo_s = y_s;
      hi_s = y_s;
    end else if (y_s < ref_y_s) begin
      lo_s = y_s;
      hi_s = ref_y_s;
    end else begin
      lo_s = ref_y_s;
      hi_s = y_s;
    end

    in_range_s = (row >= lo_s) && (row <= hi_s);
    edge_s     = ({1'b0, row} == ({1'b0, lo_s} - ONE_X)) ||
                 ({1'b0, row} == ({1'b0, hi_s} + ONE_X));
    hit_s      = enable && in_plot && in_range_s;
    aa_s       = enable && aa_enable && in_plot && !in_range_s && edge_s;
  end

  // Previous-row tracker and registered per-pixel flags.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_y_r     <= {ROW_W{1'b0}};
      prev_valid_r <= 1'b0;
      hit_r        <= 1'b0;
      aa_r         <= 1'b0;
    end else begin
      hit_r <= hit_s;
      aa_r  <= aa_s;
      if (in_plot) begin
        prev_y_r     <= y_s;
        prev_valid_r <= 1'b1;
      end else begin
        prev_y_r     <= prev_y_r;
        prev_valid_r <= prev_valid_r;
      end
    end
  end

  assign hit = hit_r;
  assign aa  = aa_r;

endmodule

// File: rtl/gpu_trace_renderer.sv
// N-channel scope trace renderer: issues display-memory reads, rasterises each
// channel and composites text/trace/trigger/frame/grid layers with latency 4.
module gpu_trace_renderer
  import gpu_trace_renderer_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int SAMPLE_W   = 9,
  parameter int ROW_W      = 10,
  parameter int COL_W      = 11,
  parameter int ADDR_W     = 9,
  parameter int PLOT_X0    = DEF_PLOT_X0,
  parameter int PLOT_X1    = DEF_PLOT_X1,
  parameter int PLOT_Y0    = DEF_PLOT_Y0,
  parameter int PLOT_Y1    = DEF_PLOT_Y1,
  parameter int MID_ROW    = DEF_MID_ROW,
  parameter int TRIG_X_OFS = DEF_TRIG_X_OFS,
  parameter int TRIG_ROWS  = DEF_TRIG_ROWS,
  parameter logic [N_CH*12-1:0] CH_COLOUR = {12'h0F0, 12'hFF0}
) (
  input  logic                     vga_clk,
  input  logic                     rst_n,
  input  logic                     on_screen_flag,
  input  logic [ROW_W-1:0]         row,
  input  logic [COL_W-1:0]         col,
  input  logic                     on_text,
  input  logic                     on_frame,
  input  logic                     on_grid,
  input  logic [N_CH*SAMPLE_W-1:0] ch_disp_sig,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic                     plot_vectors,
  input  logic                     aa_enable,
  input  logic [8:0]               trig_time,
  output logic [ADDR_W-1:0]        displ_mem_rd_addr,
  output logic [3:0]               R,
  output logic [3:0]               G,
  output logic [3:0]               B
);

  localparam logic [COL_W-1:0] X0_C     = COL_W'(PLOT_X0);
  localparam logic [COL_W-1:0] X1_C     = COL_W'(PLOT_X1);
  localparam logic [COL_W-1:0] TOFS_C   = COL_W'(TRIG_X_OFS);
  localparam logic [ROW_W-1:0] TROWS_C  = ROW_W'(TRIG_ROWS);

  logic                 in_plot_s;
  logic                 first_s;
  logic [COL_W-1:0]     trig_col_s;
  logic [ADDR_W-1:0]    rd_addr_s;
  pix_flags_t           flags_s;
  logic [N_CH-1:0]      ch_hit_s;
  logic [N_CH-1:0]      ch_aa_s;
  logic                 found_s;
  logic [11:0]          rgb_s;

  logic [ADDR_W-1:0]    rd_addr_r;
  pix_flags_t           flags_d1_r;
  pix_flags_t           flags_d2_r;
  pix_flags_t           flags_d3_r;
  logic [ROW_W-1:0]     row_d1_r;
  logic [ROW_W-1:0]     row_d2_r;
  logic                 in_plot_d1_r;
  logic                 in_plot_d2_r;
  logic                 first_d1_r;
  logic                 first_d2_r;
  logic [11:0]          rgb_r;

  // Raster-position decode feeding the address and the delay lines.
  always_comb begin
    in_plot_s  = (col >= X0_C) && (col < X1_C);
    first_s    = (col == X0_C);
    trig_col_s = COL_W'(trig_time) + TOFS_C;
    if (in_plot_s) begin
      rd_addr_s = ADDR_W'(col - X0_C);
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
    flags_s.on_screen = on_screen_flag;
    flags_s.on_text   = on_text;
    flags_s.on_frame  = on_frame;
    flags_s.on_grid   = on_grid;
    flags_s.trig      = (col == trig_col_s) && (row < TROWS_C);
  end

  // Read address plus delay lines that keep raster data aligned with memory data.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_r    <= {ADDR_W{1'b0}};
      flags_d1_r   <= FLAGS_IDLE;
      flags_d2_r   <= FLAGS_IDLE;
      flags_d3_r   <= FLAGS_IDLE;
      row_d1_r     <= {ROW_W{1'b0}};
      row_d2_r     <= {ROW_W{1'b0}};
      in_plot_d1_r <= 1'b0;
      in_plot_d2_r <= 1'b0;
      first_d1_r   <= 1'b0;
      first_d2_r   <= 1'b0;
    end else begin
      rd_addr_r    <= rd_addr_s;
      flags_d1_r   <= flags_s;
      flags_d2_r   <= flags_d1_r;
      flags_d3_r   <= flags_d2_r;
      row_d1_r     <= row;
      row_d2_r     <= row_d1_r;
      in_plot_d1_r <= in_plot_s;
      in_plot_d2_r <= in_plot_d1_r;
      first_d1_r   <= first_s;
      first_d2_r   <= first_d1_r;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    gpu_trace_hit #(
      .SAMPLE_W (SAMPLE_W),
      .ROW_W    (ROW_W),
      .PLOT_Y0  (PLOT_Y0),
      .PLOT_Y1  (PLOT_Y1),
      .MID_ROW  (MID_ROW)
    ) u_hit (
      .vga_clk      (vga_clk),
      .rst_n        (rst_n),
      .sample       (ch_disp_sig[g*SAMPLE_W +: SAMPLE_W]),
      .row          (row_d2_r),
      .in_plot      (in_plot_d2_r),
      .first_col    (first_d2_r),
      .enable       (ch_enable[g]),
      .plot_vectors (plot_vectors),
      .aa_enable    (aa_enable),
      .hit          (ch_hit_s[g]),
      .aa           (ch_aa_s[g])
    );
  end

  // Layer compositor: lower channel index wins among traces.
  always_comb begin
    rgb_s   = COLOUR_BLACK;
    found_s = 1'b0;
    if (!flags_d3_r.on_screen) begin
      rgb_s = COLOUR_BLACK;
    end else if (flags_d3_r.on_text) begin
      rgb_s = COLOUR_WHITE;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found_s && ch_hit_s[i]) begin
          rgb_s   = CH_COLOUR[i*12 +: 12];
          found_s = 1'b1;
        end else if (!found_s && ch_aa_s[i]) begin
          rgb_s   = half_colour(CH_COLOUR[i*12 +: 12]);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
      if (found_s) begin
        rgb_s = rgb_s;
      end else if (flags_d3_r.trig) begin
        rgb_s = COLOUR_TRIG;
      end else if (flags_d3_r.on_frame) begin
        rgb_s = COLOUR_FRAME;
      end else if (flags_d3_r.on_grid) begin
        rgb_s = COLOUR_GRID;
      end else begin
        rgb_s = COLOUR_BLACK;
      end
    end
  end

  // Registered pixel colour.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r <= COLOUR_BLACK;
    end else begin
      rgb_r <= rgb_s;
    end
  end

  assign displ_mem_rd_addr = rd_addr_r;
  assign R = rgb_r[11:8];
  assign G = rgb_r[7:4];
  assign B = rgb_r[3:0];

endmodule

// File: tb/tb_gpu_trace_renderer.sv
// Scoreboard bench for gpu_trace_renderer: stimulus queues expected colours,
// an independent monitor compares them four clocks after issue.
module tb_gpu_trace_renderer;

  typedef struct {
    int          due;
    logic [11:0] exp_rgb;
    string       name;
  } exp_t;

  localparam logic [3:0] VIS = 4'b1000;
  localparam logic [3:0] TXT = 4'b1100;
  localparam logic [3:0] OFF = 4'b0100;
  localparam logic [3:0] FRM = 4'b1010;
  localparam logic [3:0] GRD = 4'b1001;
  localparam logic [3:0] FG  = 4'b1011;
  localparam logic [3:0] TF  = 4'b1110;

  logic        vga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        on_screen_flag = 1'b0;
  logic [9:0]  row = 10'd0;
  logic [10:0] col = 11'd0;
  logic        on_text = 1'b0;
  logic        on_frame = 1'b0;
  logic        on_grid = 1'b0;
  logic [17:0] ch_disp_sig = 18'd0;
  logic [1:0]  ch_enable = 2'b01;
  logic        plot_vectors = 1'b0;
  logic        aa_enable = 1'b0;
  logic [8:0]  trig_time = 9'd0;
  logic [8:0]  displ_mem_rd_addr;
  logic [3:0]  R, G, B;

  logic signed [8:0] mem0 [0:511];
  logic signed [8:0] mem1 [0:511];
  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  gpu_trace_renderer dut (
    .vga_clk           (vga_clk),
    .rst_n             (rst_n),
    .on_screen_flag    (on_screen_flag),
    .row               (row),
    .col               (col),
    .on_text           (on_text),
    .on_frame          (on_frame),
    .on_grid           (on_grid),
    .ch_disp_sig       (ch_disp_sig),
    .ch_enable         (ch_enable),
    .plot_vectors      (plot_vectors),
    .aa_enable         (aa_enable),
    .trig_time         (trig_time),
    .displ_mem_rd_addr (displ_mem_rd_addr),
    .R                 (R),
    .G                 (G),
    .B                 (B)
  );

  always #5 vga_clk = ~vga_clk;

  // Cycle counter and one-cycle display memory.
  always @(posedge vga_clk) begin
    cyc         <= cyc + 1;
    ch_disp_sig <= {mem1[displ_mem_rd_addr], mem0[displ_mem_rd_addr]};
  end

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: pops every expectation that has come due and compares it.
  always begin
    @(posedge vga_clk);
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: missed due cycle %0d at %0d", e.name, e.due, cyc);
      end else begin
        check(e.name, {R, G, B}, e.exp_rgb);
      end
    end
  end

  task automatic pix(input int r, input int c, input logic [3:0] fl,
                     input logic [11:0] e, input bit chk, input string nm);
    @(negedge vga_clk);
    row            = r[9:0];
    col            = c[10:0];
    on_screen_flag = fl[3];
    on_text        = fl[2];
    on_frame       = fl[1];
    on_grid        = fl[0];
    if (chk) sb.push_back('{cyc + 4, e, nm});
  endtask

  task automatic cfg(input logic vec, input logic aa, input logic [1:0] en, input logic [8:0] tt);
    repeat (6) @(negedge vga_clk);
    plot_vectors = vec;
    aa_enable    = aa;
    ch_enable    = en;
    trig_time    = tt;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 512; i++) begin
      mem0[i] = -9'sd200;
      mem1[i] = -9'sd200;
    end
    mem0[0]   = -9'sd100;
    mem0[100] = 9'sd20;
    mem0[120] = 9'sd10;
    mem0[121] = 9'sd40;
    mem0[140] = -9'sd256;
    mem0[141] = 9'sd255;
    mem0[200] = 9'sd0;
    mem1[200] = 9'sd0;
    mem0[499] = 9'sd200;

    // Reset held with the raster running on an in-plot text pixel.
    repeat (3) pix(10, 250, TXT, 12'h000, 1'b0, "");
    repeat (2) begin
      @(posedge vga_clk);
      #1;
      check("rst_rgb", {R, G, B}, 12'h000);
      check("rst_addr", {3'b000, displ_mem_rd_addr}, 12'h000);
    end
    @(negedge vga_clk);
    rst_n = 1'b1;
    k = cyc;
    sb.push_back('{k + 1, 12'h000, "post_rst_black1"});
    sb.push_back('{k + 2, 12'h000, "post_rst_black2"});
    sb.push_back('{k + 3, 12'h000, "post_rst_black3"});
    sb.push_back('{k + 4, 12'hFFF, "post_rst_first"});
    pix(10, 250, TXT, 12'hFFF, 1'b1, "post_rst_text");
    pix(10, 250, VIS, 12'h000, 1'b1, "post_rst_vis");

    // Dot mode, sample +20 at col 300 -> row 280.
    cfg(1'b0, 1'b1, 2'b01, 9'd0);
    pix(280, 300, VIS, 12'hFF0, 1'b1, "dot_hit");
    pix(279, 300, VIS, 12'h770, 1'b1, "dot_aa_above");
    pix(281, 300, VIS, 12'h770, 1'b1, "dot_aa_below");
    pix(278, 300, VIS, 12'h000, 1'b1, "dot_clear_above");
    pix(282, 300, VIS, 12'h000, 1'b1, "dot_clear_below");
    cfg(1'b0, 1'b0, 2'b01, 9'd0);
    pix(280, 300, VIS, 12'hFF0, 1'b1, "dot_hit_noaa");
    pix(279, 300, VIS, 12'h000, 1'b1, "dot_noaa_above");
    pix(281, 300, VIS, 12'h000, 1'b1, "dot_noaa_below");

    // Vector mode: 10 at col 320, 40 at col 321 -> col 321 spans rows 260..290.
    cfg(1'b1, 1'b1, 2'b01, 9'd0);
    begin
      int rows[7] = '{258, 259, 260, 275, 290, 291, 292};
      logic [11:0] cols[7] = '{12'h000, 12'h770, 12'hFF0, 12'hFF0, 12'hFF0, 12'h770, 12'h000};
      for (int i = 0; i < 7; i++) begin
        pix(rows[i], 320, VIS, 12'h000, 1'b0, "");
        pix(rows[i], 321, VIS, cols[i], 1'b1, $sformatf("vec_row%0d", rows[i]));
      end
    end

    // Line start: +200 at col 699 then -100 at col 200 must not connect.
    cfg(1'b1, 1'b0, 2'b01, 9'd0);
    begin
      int rows[5] = '{400, 399, 300, 250, 100};
      for (int i = 0; i < 5; i++) begin
        pix(rows[i], 699, VIS, 12'h000, 1'b0, "");
        pix(rows[i], 200, VIS, (rows[i] == 400) ? 12'hFF0 : 12'h000, 1'b1,
            $sformatf("linestart_row%0d", rows[i]));
      end
    end

    // Clamp at both plot limits.
    cfg(1'b0, 1'b1, 2'b01, 9'd0);
    pix(550, 340, VIS, 12'hFF0, 1'b1, "clamp_lo_hit");
    pix(549, 340, VIS, 12'h770, 1'b1, "clamp_lo_aa_above");
    pix(551, 340, VIS, 12'h770, 1'b1, "clamp_lo_aa_below");
    pix(552, 340, VIS, 12'h000, 1'b1, "clamp_lo_clear");
    pix(548, 340, VIS, 12'h000, 1'b1, "clamp_lo_clear2");
    pix(50, 341, VIS, 12'hFF0, 1'b1, "clamp_hi_hit");
    pix(49, 341, VIS, 12'h770, 1'b1, "clamp_hi_aa");
    pix(51, 341, VIS, 12'h770, 1'b1, "clamp_hi_aa_below");
    pix(48, 341, VIS, 12'h000, 1'b1, "clamp_hi_clear");

    // Channel priority and layer priority at col 400, both samples 0.
    cfg(1'b0, 1'b1, 2'b11, 9'd0);
    pix(300, 400, VIS, 12'hFF0, 1'b1, "prio_ch0_wins");
    pix(301, 400, VIS, 12'h770, 1'b1, "prio_ch0_aa");
    pix(300, 400, TXT, 12'hFFF, 1'b1, "prio_text");
    pix(300, 400, OFF, 12'h000, 1'b1, "prio_offscreen");
    cfg(1'b0, 1'b1, 2'b10, 9'd0);
    pix(300, 400, VIS, 12'h0F0, 1'b1, "prio_ch1_only");
    pix(301, 400, VIS, 12'h070, 1'b1, "prio_ch1_aa");
    cfg(1'b0, 1'b1, 2'b00, 9'd0);
    pix(300, 400, VIS, 12'h000, 1'b1, "prio_none");

    // Plot-window column boundaries.
    cfg(1'b0, 1'b0, 2'b01, 9'd0);
    pix(100, 699, VIS, 12'hFF0, 1'b1, "bound_last_col");
    pix(400, 700, VIS, 12'h000, 1'b1, "bound_x1_excl");
    pix(400, 199, VIS, 12'h000, 1'b1, "bound_before_x0");
    pix(400, 200, VIS, 12'hFF0, 1'b1, "bound_first_col");

    // Trigger marker, frame and grid layers.
    cfg(1'b0, 1'b0, 2'b01, 9'd7);
    pix(50, 200, VIS, 12'h770, 1'b1, "trig_row50");
    pix(99, 200, VIS, 12'h770, 1'b1, "trig_row99");
    pix(100, 200, VIS, 12'h000, 1'b1, "trig_row100");
    pix(50, 201, VIS, 12'h000, 1'b1, "trig_col201");
    pix(50, 200, FRM, 12'h770, 1'b1, "trig_over_frame");
    pix(50, 100, FRM, 12'h444, 1'b1, "frame");
    pix(50, 100, GRD, 12'h222, 1'b1, "grid");
    pix(50, 100, FG, 12'h444, 1'b1, "frame_over_grid");
    pix(50, 100, TF, 12'hFFF, 1'b1, "text_over_frame");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge vga_clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s: never checked (due %0d)", e.name, e.due);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
